// File: rtl/crc8_frame_tx.sv
// crc8_frame_tx: transmit-side CRC-8 generator (bit-serial, MSB first).
// Forwards each data byte, then appends the CRC byte after the frame's last byte.
module crc8_frame_tx #(
    parameter logic [7:0] POLY   = 8'h07,
    parameter logic [7:0] INIT   = 8'h00,
    parameter logic [7:0] XOROUT = 8'h00
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       out_last,
    input  logic       out_ready,
    output logic       crc_busy
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        EMIT_DATA,
        EMIT_CRC
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] crc_q, crc_d;
    logic [7:0] byte_q, byte_d;
    logic       last_q, last_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] out_data_q, out_data_d;
    logic       out_valid_q, out_valid_d;
    logic       out_last_q, out_last_d;
    logic       fb;

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_d     = state_q;
        crc_d       = crc_q;
        byte_d      = byte_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        fb          = crc_q[7] ^ byte_q[3'd7 - cnt_q];
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        out_data_d  = 8'h00;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    byte_d  = in_data;
                    last_d  = in_last;
                    cnt_d   = 3'd0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                crc_d = {crc_q[6:0], 1'b0} ^ (fb ? POLY : 8'h00);
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    state_d = EMIT_DATA;
                end
            end
            EMIT_DATA: begin
                if (out_ready) begin
                    state_d = last_q ? EMIT_CRC : IDLE;
                end
            end
            EMIT_CRC: begin
                if (out_ready) begin
                    crc_d   = INIT;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Outputs follow the state being entered, so they are glitch-free registers
        if (state_d == EMIT_DATA) begin
            out_valid_d = 1'b1;
            out_data_d  = byte_d;
        end else if (state_d == EMIT_CRC) begin
            out_valid_d = 1'b1;
            out_last_d  = 1'b1;
            out_data_d  = crc_d ^ XOROUT;
        end
    end

    // State and datapath registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            crc_q       <= INIT;
            byte_q      <= 8'h00;
            last_q      <= 1'b0;
            cnt_q       <= 3'd0;
            out_data_q  <= 8'h00;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            crc_q       <= crc_d;
            byte_q      <= byte_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    assign in_ready  = reset && (state_q == IDLE);
    assign crc_busy  = (state_q == SHIFT);
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_crc8_frame_tx.sv
// tb_crc8_frame_tx: drives two crc8_frame_tx instances (default and SAE-J1850
// parameters) with identical frames and checks both against a byte-wise CRC model.
module tb_crc8_frame_tx;

    typedef logic [7:0] byte_q_t[$];
    typedef logic [8:0] obs_q_t[$];

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic       out_ready = 1'b0;
    logic       in_ready, in_ready_b;
    logic [7:0] out_data_a, out_data_b;
    logic       out_valid_a, out_valid_b;
    logic       out_last_a, out_last_b;
    logic       crc_busy, crc_busy_b;

    int     asserts = 0;
    int     fails = 0;
    obs_q_t qa, qb;
    int     last_lat;
    bit     hold_ok, rdy_low_ok, crc_follow_ok;

    always #5 clock = ~clock;

    crc8_frame_tx dut_a (
        .clock(clock), .reset(reset),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready),
        .out_data(out_data_a), .out_valid(out_valid_a), .out_last(out_last_a),
        .out_ready(out_ready), .crc_busy(crc_busy)
    );

    crc8_frame_tx #(.POLY(8'h1D), .INIT(8'hFF), .XOROUT(8'hFF)) dut_b (
        .clock(clock), .reset(reset),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready_b),
        .out_data(out_data_b), .out_valid(out_valid_b), .out_last(out_last_b),
        .out_ready(out_ready), .crc_busy(crc_busy_b)
    );

    // Byte-at-a-time CRC: xor the byte into the register, then 8 polynomial steps
    function automatic obs_q_t exp_frame(byte_q_t f, logic [7:0] poly,
                                         logic [7:0] init, logic [7:0] xo);
        obs_q_t     r;
        logic [7:0] c;
        c = init;
        foreach (f[i]) begin
            r.push_back({1'b0, f[i]});
            c = c ^ f[i];
            for (int k = 0; k < 8; k++)
                c = c[7] ? ((c << 1) ^ poly) : (c << 1);
        end
        r.push_back({1'b1, c ^ xo});
        return r;
    endfunction

    task automatic send_byte(input logic [7:0] d, input logic l, input int stall);
        int         n;
        logic [8:0] held;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clock);
            n++;
        end
        asserts++;
        if (n >= 100) begin
            fails++;
            $display("FAIL in_ready_timeout got %b want 1", in_ready);
        end
        in_data  = d;
        in_last  = l;
        in_valid = 1'b1;
        @(negedge clock);
        n = 0;
        while (!out_valid_a && n < 100) begin
            in_valid = 1'($urandom);
            in_data  = 8'($urandom);
            in_last  = 1'($urandom);
            @(negedge clock);
            n++;
        end
        last_lat = n;
        asserts++;
        if (n >= 100) begin
            fails++;
            $display("FAIL out_valid_timeout got %b want 1", out_valid_a);
        end
        hold_ok    = 1'b1;
        rdy_low_ok = 1'b1;
        held       = {out_last_a, out_data_a};
        repeat (stall) begin
            @(negedge clock);
            if ({out_last_a, out_data_a} !== held || !out_valid_a) hold_ok = 1'b0;
            if (in_ready) rdy_low_ok = 1'b0;
        end
        qa.push_back({out_last_a, out_data_a});
        qb.push_back({out_last_b, out_data_b});
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        if (l) begin
            crc_follow_ok = out_valid_a && out_valid_b;
            qa.push_back({out_last_a, out_data_a});
            qb.push_back({out_last_b, out_data_b});
            out_ready = 1'b1;
            @(negedge clock);
            out_ready = 1'b0;
        end
    endtask

    task automatic run_frame(input byte_q_t f, input int stall);
        qa.delete();
        qb.delete();
        foreach (f[i]) send_byte(f[i], (i == f.size() - 1), stall);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clock);
        asserts += 6;
        if (in_ready !== 1'b0) begin fails++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
        if (out_valid_a !== 1'b0) begin fails++; $display("FAIL rst_out_valid got %b want 0", out_valid_a); end
        if (out_last_a !== 1'b0) begin fails++; $display("FAIL rst_out_last got %b want 0", out_last_a); end
        if (out_data_a !== 8'h00) begin fails++; $display("FAIL rst_out_data got %h want 00", out_data_a); end
        if (crc_busy !== 1'b0) begin fails++; $display("FAIL rst_crc_busy got %b want 0", crc_busy); end
        if (out_valid_b !== 1'b0) begin fails++; $display("FAIL rst_out_valid_b got %b want 0", out_valid_b); end
        reset = 1'b1;
        #1;
        asserts++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_release_in_ready got %b want 1", in_ready); end
        @(negedge clock);
    endtask

    task automatic test_single();
        byte_q_t f;
        obs_q_t  eb;
        f  = '{8'h68};
        eb = exp_frame(f, 8'h1D, 8'hFF, 8'hFF);
        run_frame(f, 0);
        asserts += 5;
        if (qa.size() != 2) begin fails++; $display("FAIL single_count got %0d want 2", qa.size()); end
        if (qa[0] !== 9'h068) begin fails++; $display("FAIL single_data got %h want 068", qa[0]); end
        if (qa[1] !== 9'h11F) begin fails++; $display("FAIL single_crc got %h want 11f", qa[1]); end
        if (last_lat != 8) begin fails++; $display("FAIL single_latency got %0d want 8", last_lat); end
        if (qb[1] !== eb[1]) begin fails++; $display("FAIL single_crc_b got %h want %h", qb[1], eb[1]); end
    endtask

    task automatic test_check_string();
        byte_q_t f;
        obs_q_t  ea;
        f  = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        ea = exp_frame(f, 8'h07, 8'h00, 8'h00);
        run_frame(f, 0);
        foreach (ea[i]) begin
            asserts++;
            if (i >= qa.size() || qa[i] !== ea[i]) begin
                fails++;
                $display("FAIL check_a[%0d] got %h want %h", i, (i < qa.size()) ? qa[i] : 9'h0, ea[i]);
            end
        end
        asserts += 3;
        if (qa.size() == 10 && qa[9] !== 9'h1F4) begin fails++; $display("FAIL check_crc got %h want 1f4", qa[9]); end
        if (qb.size() == 10 && qb[9] !== 9'h14B) begin fails++; $display("FAIL check_crc_b got %h want 14b", qb[9]); end
        if (!crc_follow_ok) begin fails++; $display("FAIL check_crc_follow got 0 want 1"); end
    endtask

    task automatic test_back_to_back();
        byte_q_t f;
        f = '{8'h01};
        run_frame(f, 0);
        asserts++;
        if (qa[1] !== 9'h107) begin fails++; $display("FAIL b2b_first got %h want 107", qa[1]); end
        f = '{8'h00, 8'h00};
        run_frame(f, 0);
        asserts++;
        if (qa[2] !== 9'h100) begin fails++; $display("FAIL b2b_second got %h want 100", qa[2]); end
    endtask

    task automatic test_backpressure();
        byte_q_t f;
        f = '{8'h68};
        run_frame(f, 5);
        asserts += 4;
        if (!hold_ok) begin fails++; $display("FAIL bp_hold got 0 want 1"); end
        if (!rdy_low_ok) begin fails++; $display("FAIL bp_in_ready got 1 want 0"); end
        if (qa[0] !== 9'h068) begin fails++; $display("FAIL bp_data got %h want 068", qa[0]); end
        if (qa[1] !== 9'h11F) begin fails++; $display("FAIL bp_crc got %h want 11f", qa[1]); end
    endtask

    task automatic test_reset_midframe();
        byte_q_t f;
        obs_q_t  eb;
        qa.delete();
        qb.delete();
        send_byte(8'hAA, 1'b0, 0);
        in_data  = 8'h55;
        in_last  = 1'b1;
        in_valid = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
        repeat (2) @(negedge clock);
        asserts++;
        if (crc_busy !== 1'b1) begin fails++; $display("FAIL mid_busy got %b want 1", crc_busy); end
        reset = 1'b0;
        #1;
        asserts += 5;
        if (in_ready !== 1'b0) begin fails++; $display("FAIL mid_in_ready got %b want 0", in_ready); end
        if (out_valid_a !== 1'b0) begin fails++; $display("FAIL mid_out_valid got %b want 0", out_valid_a); end
        if (out_last_a !== 1'b0) begin fails++; $display("FAIL mid_out_last got %b want 0", out_last_a); end
        if (out_data_a !== 8'h00) begin fails++; $display("FAIL mid_out_data got %h want 00", out_data_a); end
        if (crc_busy !== 1'b0) begin fails++; $display("FAIL mid_crc_busy got %b want 0", crc_busy); end
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        f  = '{8'h01};
        eb = exp_frame(f, 8'h1D, 8'hFF, 8'hFF);
        run_frame(f, 0);
        asserts += 2;
        if (qa[1] !== 9'h107) begin fails++; $display("FAIL mid_after_crc got %h want 107", qa[1]); end
        if (qb[1] !== eb[1]) begin fails++; $display("FAIL mid_after_crc_b got %h want %h", qb[1], eb[1]); end
    endtask

    task automatic test_random();
        byte_q_t f;
        obs_q_t  ea, eb;
        int      len;
        for (int fr = 0; fr < 20; fr++) begin
            f.delete();
            len = $urandom_range(1, 5);
            for (int j = 0; j < len; j++) f.push_back(8'($urandom));
            ea = exp_frame(f, 8'h07, 8'h00, 8'h00);
            eb = exp_frame(f, 8'h1D, 8'hFF, 8'hFF);
            run_frame(f, $urandom_range(0, 3));
            foreach (ea[i]) begin
                asserts += 2;
                if (i >= qa.size() || qa[i] !== ea[i]) begin
                    fails++;
                    $display("FAIL rand_a f%0d[%0d] got %h want %h", fr, i, (i < qa.size()) ? qa[i] : 9'h0, ea[i]);
                end
                if (i >= qb.size() || qb[i] !== eb[i]) begin
                    fails++;
                    $display("FAIL rand_b f%0d[%0d] got %h want %h", fr, i, (i < qb.size()) ? qb[i] : 9'h0, eb[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_check_string();
        test_back_to_back();
        test_backpressure();
        test_reset_midframe();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
